// File: rtl/spi_codec_responder_if.sv
// SPI pins between the codec/daughterboard master and a responder.
// sclk idles low, sen is active low, miso joins the master's OR-tree.
interface spi_codec_responder_if;
    logic sclk;
    logic sen;
    logic mosi;
    logic miso;

    modport master (
        output sclk,
        output sen,
        output mosi,
        input  miso
    );

    modport slave (
        input  sclk,
        input  sen,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/spi_codec_responder.sv
// SPI responder with a 2**AW x 8 register file; SPI pins are oversampled in clk.
// Define SPI_RESP_AUTOINC_EN to stream bytes with address auto-increment.
module spi_codec_responder #(
    parameter int         AW        = 7,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_codec_responder_if.slave  spi,
    output logic                  wr_stb,
    output logic [AW-1:0]         wr_addr,
    output logic [7:0]            wr_data,
    output logic                  frame_err,
    input  logic [AW-1:0]         peek_addr,
    output logic [7:0]            peek_data
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        INSTR,
        DATA,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [2:0]    sclk_q;
    logic [2:0]    sen_q;
    logic [1:0]    mosi_q;
    logic [2:0]    bit_cnt;
    logic          rw;
    logic [AW-1:0] addr;
    logic [7:0]    shreg;
    logic [7:0]    shin;
    logic          miso_q;
    logic [7:0]    mem [DEPTH];
    logic          rise;
    logic          fall;
    logic          sen_fall;
    logic          sen_rise;
    logic          byte_end;
`ifdef SPI_RESP_AUTOINC_EN
    logic [AW-1:0] addr_nx;
    assign addr_nx = addr + AW'(1);
`endif

    // [0],[1] synchronise, [2] holds the previous level for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= 3'b000;
            sen_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], spi.sclk};
            sen_q  <= {sen_q[1:0], spi.sen};
            mosi_q <= {mosi_q[0], spi.mosi};
        end
    end

    assign rise     = sclk_q[1] & ~sclk_q[2] & ~sen_q[1];
    assign fall     = ~sclk_q[1] & sclk_q[2] & ~sen_q[1];
    assign sen_fall = ~sen_q[1] & sen_q[2];
    assign sen_rise = sen_q[1] & ~sen_q[2];
    assign byte_end = rise & (bit_cnt == 3'd7);
    assign shin     = {shreg[6:0], mosi_q[1]};
    assign spi.miso = miso_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (sen_fall) state_nx = INSTR;
            INSTR: begin
                if (sen_rise)      state_nx = IDLE;
                else if (byte_end) state_nx = DATA;
            end
            DATA: begin
                if (sen_rise) state_nx = IDLE;
`ifndef SPI_RESP_AUTOINC_EN
                else if (byte_end) state_nx = DRAIN;
`endif
            end
            DRAIN:   if (sen_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= 3'd0;
            rw        <= 1'b0;
            addr      <= '0;
            shreg     <= 8'h00;
            miso_q    <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            frame_err <= 1'b0;
            peek_data <= 8'h00;
            for (int i = 0; i < DEPTH; i++)
                mem[AW'(i)] <= RESET_VAL;
        end else begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            peek_data <= mem[peek_addr];
            unique case (state)
                IDLE: begin
                    bit_cnt <= 3'd0;
                    miso_q  <= 1'b0;
                end
                INSTR: begin
                    if (sen_rise) begin
                        frame_err <= (bit_cnt != 3'd0);
                    end else if (rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shreg   <= shin;
                        if (byte_end) begin
                            rw   <= shin[7];
                            addr <= shin[AW-1:0];
                            if (shin[7])
                                shreg <= mem[shin[AW-1:0]];
                        end
                    end
                end
                DATA: begin
                    if (sen_rise) begin
                        frame_err <= (bit_cnt != 3'd0);
                        miso_q    <= 1'b0;
                    end else if (rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (!rw)
                            shreg <= shin;
                        if (byte_end) begin
                            if (!rw) begin
                                mem[addr] <= shin;
                                wr_stb    <= 1'b1;
                                wr_addr   <= addr;
                                wr_data   <= shin;
                            end
`ifdef SPI_RESP_AUTOINC_EN
                            addr <= addr_nx;
                            if (rw)
                                shreg <= mem[addr_nx];
`else
                            miso_q <= 1'b0;
`endif
                        end
                    end else if (fall && rw) begin
                        // read data leaves on the falling edge, MSB first
                        miso_q <= shreg[7];
                        shreg  <= {shreg[6:0], 1'b0};
                    end
                end
                DRAIN:   miso_q <= 1'b0;
                default: miso_q <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_codec_responder.sv
// Bench for spi_codec_responder: directed frames plus random frames
// checked against an array model of the register file.
module tb_spi_codec_responder;
    localparam int AW = 7;
    localparam int HB = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_err;
    logic [AW-1:0] peek_addr;
    logic [7:0]    peek_data;

    spi_codec_responder_if spi ();

    spi_codec_responder #(
        .AW        (AW),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spi       (spi),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .peek_addr (peek_addr),
        .peek_data (peek_data)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          stb_cyc = 0;
    int          rise16_cyc = 0;
    int          ferr_cnt = 0;
    int          sen_hi = 0;
    int          miso_viol = 0;
    int          e0;
    int          v0;
    logic [7:0]  peek_at_stb = 8'h00;
    logic [7:0]  peek_after = 8'h00;
    bit          stb_last = 1'b0;
    logic [14:0] stb_q [$];
    logic [7:0]  mem_m [128];
    logic [7:0]  tx [$];
    logic        rx_bits [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (stb_last) peek_after = peek_data;
        if (wr_stb) begin
            stb_q.push_back({wr_addr, wr_data});
            stb_cyc     = cyc;
            peek_at_stb = peek_data;
        end
        stb_last = wr_stb;
        if (frame_err) ferr_cnt++;
        if (spi.sen) sen_hi++;
        else         sen_hi = 0;
        if (sen_hi >= 4 && spi.miso !== 1'b0) miso_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input int nbits, input bit keep_open);
        logic [7:0] b;
        rx_bits.delete();
        @(negedge clk);
        spi.sen = 1'b0;
        wait_clk(HB);
        for (int i = 0; i < nbits; i++) begin
            b = tx[i / 8];
            spi.mosi = b[7 - (i % 8)];
            wait_clk(HB);
            rx_bits.push_back(spi.miso);
            spi.sclk = 1'b1;
            if (i == 15) rise16_cyc = cyc;
            wait_clk(HB);
            spi.sclk = 1'b0;
        end
        wait_clk(HB);
        if (!keep_open) begin
            spi.sen  = 1'b1;
            spi.mosi = 1'b0;
            wait_clk(8);
        end
    endtask

    task automatic mk_tx(input bit rd, input logic [6:0] a);
        tx.delete();
        tx.push_back({rd, a});
        for (int k = 0; k < 5; k++) tx.push_back(8'($urandom));
    endtask

    task automatic run_frame(input bit rd, input logic [6:0] a,
                             input int nbits);
        int         nfull;
        int         nact;
        int         nrd;
        int         nbytes;
        int         f0;
        bit         err_exp;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        logic [7:0] d;
        f0 = ferr_cnt;
        stb_q.delete();
        xfer(nbits, 1'b0);
        nfull = (nbits >= 8) ? (nbits - 8) / 8 : 0;
`ifdef SPI_RESP_AUTOINC_EN
        nact    = nfull;
        nrd     = 1000;
        err_exp = (nbits % 8) != 0;
`else
        nact    = (nfull > 1) ? 1 : nfull;
        nrd     = 1;
        err_exp = ((nbits % 8) != 0) && (nbits < 16);
`endif
        nbytes = (nbits + 7) / 8;
        for (int k = 0; k < nbytes; k++) begin
            exp_b = 8'h00;
            got_b = 8'h00;
            if (k >= 1 && rd && (k - 1) < nrd)
                d = mem_m[(a + k - 1) % 128];
            else
                d = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (k * 8 + j < nbits) begin
                    got_b[7 - j] = rx_bits[k * 8 + j];
                    exp_b[7 - j] = d[7 - j];
                end
            end
            chk(rd ? "rd_byte" : "wr_miso", got_b, exp_b);
        end
        if (!rd)
            for (int k = 0; k < nact; k++)
                mem_m[(a + k) % 128] = tx[k + 1];
        chk("stb_cnt", stb_q.size(), rd ? 0 : nact);
        for (int k = 0; k < stb_q.size() && k < nact; k++) begin
            chk("stb_addr", stb_q[k][14:8], (a + k) % 128);
            chk("stb_data", stb_q[k][7:0], tx[k + 1]);
        end
        chk("frame_err", ferr_cnt - f0, err_exp);
    endtask

    task automatic peek_chk(input logic [6:0] a);
        @(negedge clk);
        peek_addr = a;
        @(negedge clk);
        chk("peek", peek_data, mem_m[a]);
    endtask

    initial begin
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        reset_n   = 1'b0;
        spi.sen   = 1'b1;
        spi.sclk  = 1'b0;
        spi.mosi  = 1'b0;
        peek_addr = '0;
        wait_clk(3);
        chk("rst_outs", {wr_stb, frame_err, spi.miso, peek_data,
                         wr_addr, wr_data}, 0);
        reset_n = 1'b1;
        wait_clk(4);
        peek_chk(7'h7F);
        peek_chk(7'h05);

        // write 05 <= A5, with latency and same-cycle peek ordering
        mk_tx(1'b0, 7'h05);
        tx[1] = 8'hA5;
        run_frame(1'b0, 7'h05, 16);
        chk("stb_lat", stb_cyc - rise16_cyc, 3);
        chk("peek_old", peek_at_stb, 8'h00);
        chk("peek_new", peek_after, 8'hA5);
        peek_chk(7'h05);

        // read back 05
        mk_tx(1'b1, 7'h05);
        run_frame(1'b1, 7'h05, 16);
        chk("miso_after", spi.miso, 1'b0);

        // partial frame after 11 rises
        mk_tx(1'b0, 7'h10);
        run_frame(1'b0, 7'h10, 11);
        peek_chk(7'h10);
        mk_tx(1'b1, 7'h05);
        run_frame(1'b1, 7'h05, 16);

        // three bytes at the top of the address space
        mk_tx(1'b0, 7'h7F);
        tx[1] = 8'h11;
        tx[2] = 8'h22;
        tx[3] = 8'h33;
        run_frame(1'b0, 7'h7F, 32);
        peek_chk(7'h7F);
        peek_chk(7'h00);
        peek_chk(7'h01);

        // reset in the middle of a read data byte
        mk_tx(1'b1, 7'h05);
        xfer(10, 1'b1);
        chk("miso_mid", spi.miso, mem_m[5][5]);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outs", {wr_stb, frame_err, spi.miso, peek_data,
                             wr_addr, wr_data}, 0);
        spi.sen  = 1'b1;
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);
        peek_chk(7'h05);
        peek_chk(7'h7F);
        mk_tx(1'b0, 7'h05);
        run_frame(1'b0, 7'h05, 16);
        mk_tx(1'b1, 7'h05);
        run_frame(1'b1, 7'h05, 16);

        // clocking with sen high must do nothing
        e0 = ferr_cnt;
        v0 = miso_viol;
        stb_q.delete();
        for (int i = 0; i < 40; i++) begin
            spi.mosi = 1'($urandom_range(0, 1));
            spi.sclk = ~spi.sclk;
            wait_clk(HB);
        end
        spi.mosi = 1'b0;
        chk("idle_stb", stb_q.size(), 0);
        chk("idle_ferr", ferr_cnt - e0, 0);
        chk("idle_miso", miso_viol - v0, 0);

        // random frames against the model
        for (int n = 0; n < 30; n++) begin
            bit         rd;
            logic [6:0] a;
            int         nb;
            rd = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            nb = $urandom_range(1, 40);
            mk_tx(rd, a);
            run_frame(rd, a, nb);
            peek_chk(7'($urandom_range(0, 127)));
        end

        for (int i = 0; i < 128; i++) peek_chk(7'(i));
        chk("miso_sen_hi", miso_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
